// File: rtl/reg_file_sync.sv
// reg_file_sync: parametrised register file with two registered read ports,
// one write port and a hardware clear sequencer that zeroes every entry after
// reset or on clear_req.
// Optional build macro: REGFILE_BYPASS_EN. When defined, a read of the address
// being written on the same edge returns the new data (write-first). When
// undefined, it returns the old contents (read-first).
//
// state   | meaning
// S_IDLE  | normal operation, user writes and reads accepted
// S_CLEAR | sweep writing 0 to entry[ptr], busy high, reads return 0

module reg_file_sync #(
    parameter int WIDTH    = 16,
    parameter int REGBITS  = 4,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               regwrite,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    input  logic               clear_req,
    output logic               busy
);

    localparam int DEPTH = 2 ** REGBITS;
    localparam logic [REGBITS:0] PTR_LAST = {1'b0, {REGBITS{1'b1}}};

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t             state_q;
    logic [REGBITS:0]   ptr_q;
    logic               busy_q;
    logic [WIDTH-1:0]   rd1_q, rd2_q;
    logic [WIDTH-1:0]   rd1_d, rd2_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               user_wr;
    logic               mem_we;
    logic [REGBITS-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_wd;

    // Select between the clear sweep and an accepted user write for the array port.
    always_comb begin
        user_wr = (state_q == S_IDLE) && !clear_req && regwrite &&
                  !((ZERO_REG != 0) && (wa == '0));
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wd  = wd;
        if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = ptr_q[REGBITS-1:0];
            mem_wd = '0;
        end else if (user_wr) begin
            mem_we = 1'b1;
        end
    end

    // Read data for the next edge, with optional write-first forwarding and entry-0 masking.
    always_comb begin
        rd1_d = mem_q[ra1];
        rd2_d = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if (user_wr && (wa == ra1)) rd1_d = wd;
        if (user_wr && (wa == ra2)) rd2_d = wd;
`endif
        if ((ZERO_REG != 0) && (ra1 == '0)) rd1_d = '0;
        if ((ZERO_REG != 0) && (ra2 == '0)) rd2_d = '0;
    end

    // Storage array; contents are left unreset and the sweep defines them.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    // Sequencer FSM with registered busy and read outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state_q <= S_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        rd1_q   <= '0;
                        rd2_q   <= '0;
                    end else begin
                        rd1_q <= rd1_d;
                        rd2_q <= rd2_d;
                    end
                end
            endcase
        end
    end

    assign rd1  = rd1_q;
    assign rd2  = rd2_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_sync.sv
// Bench for reg_file_sync: two instances (ZERO_REG=1 and ZERO_REG=0) share
// stimulus; a per-cycle model plus directed literal checks.

module tb_reg_file_sync;

    localparam int DEPTH = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        regwrite = 1'b0;
    logic        clear_req = 1'b0;
    logic [3:0]  wa = '0, ra1 = '0, ra2 = '0;
    logic [15:0] wd = '0;

    logic [15:0] rd1_z, rd2_z, rd1_n, rd2_n;
    logic        busy_z, busy_n;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    reg_file_sync #(.WIDTH(16), .REGBITS(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
        .clear_req(clear_req), .busy(busy_z)
    );

    reg_file_sync #(.WIDTH(16), .REGBITS(4), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .clear_req(clear_req), .busy(busy_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 1 = ZERO_REG=1 instance, index 0 = ZERO_REG=0 instance.
    logic [15:0] m_mem [2][DEPTH];
    logic [15:0] m_rd1 [2];
    logic [15:0] m_rd2 [2];
    int          sweep_left = DEPTH;

    function automatic logic [15:0] m_read(input int k, input logic [3:0] ra, input bit acc);
        if (k == 1 && ra == 4'd0) return 16'h0000;
        if (BYPASS && acc && wa == ra) return wd;
        return m_mem[k][ra];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_left = DEPTH;
            for (int k = 0; k < 2; k++) begin
                m_rd1[k] = '0;
                m_rd2[k] = '0;
            end
        end else if (sweep_left > 0) begin
            sweep_left--;
            for (int k = 0; k < 2; k++) begin
                m_rd1[k] = '0;
                m_rd2[k] = '0;
                if (sweep_left == 0)
                    for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;
            end
        end else if (clear_req) begin
            sweep_left = DEPTH;
            for (int k = 0; k < 2; k++) begin
                m_rd1[k] = '0;
                m_rd2[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc = regwrite && !(k == 1 && wa == 4'd0);
                m_rd1[k] = m_read(k, ra1, acc);
                m_rd2[k] = m_read(k, ra2, acc);
                if (acc) m_mem[k][wa] = wd;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_z", busy_z, sweep_left > 0);
            chk("busy_n", busy_n, sweep_left > 0);
            chk("rd1_z",  rd1_z,  m_rd1[1]);
            chk("rd2_z",  rd2_z,  m_rd2[1]);
            chk("rd1_n",  rd1_n,  m_rd1[0]);
            chk("rd2_n",  rd2_n,  m_rd2[0]);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        regwrite = 1'b1; wa = a; wd = d;
        @(negedge clk);
        regwrite = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        ra1 = a1; ra2 = a2;
        @(negedge clk);
    endtask

    // Edges until busy is seen low; optionally pokes writes and clear_req mid-sweep.
    task automatic count_busy(input bit poke, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (!busy_z) break;
            chk("sweep_rd1_zero", rd1_z, 16'h0000);
            if (poke) begin
                if (i == 3) begin regwrite = 1'b1; wa = 4'd8; wd = 16'h5555; end
                if (i == 5) clear_req = 1'b1;
                if (i == 6) begin clear_req = 1'b0; regwrite = 1'b0; end
            end
        end
    endtask

    logic [3:0]  t_addr [4] = '{4'd1, 4'd2, 4'd4, 4'd15};
    logic [15:0] t_data [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7A5C};

    initial begin
        int n;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy_z, 1'b1);
        chk("reset_rd1",  rd1_z, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        count_busy(1'b0, n);
        chk("post_reset_sweep_edges", n, 16);

        for (int i = 0; i < DEPTH; i++) begin
            rd(4'(i), 4'(DEPTH - 1 - i));
            chk("init_rd1_n", rd1_n, 16'h0000);
            chk("init_rd2_n", rd2_n, 16'h0000);
        end

        wr(4'd3, 16'hBEEF);
        rd(4'd3, 4'd3);
        chk("beef_rd1", rd1_z, 16'hBEEF);
        chk("beef_rd2", rd2_z, 16'hBEEF);
        chk("beef_rd1_n", rd1_n, 16'hBEEF);

        wr(4'd0, 16'h1234);
        rd(4'd0, 4'd3);
        chk("zero_reg_rd1", rd1_z, 16'h0000);
        chk("plain_reg0_rd1", rd1_n, 16'h1234);

        wr(4'd5, 16'h1111);
        regwrite = 1'b1; wa = 4'd5; wd = 16'h2222; ra1 = 4'd5; ra2 = 4'd0;
        @(negedge clk);
        regwrite = 1'b0;
        chk("same_edge_rd1", rd1_z, BYPASS ? 16'h2222 : 16'h1111);
        chk("same_edge_rd2_n", rd2_n, 16'h1234);
        @(negedge clk);
        chk("after_same_edge_rd1", rd1_z, 16'h2222);

        // Entry-0 write with read of 0 on the same edge: never forwarded when dropped.
        regwrite = 1'b1; wa = 4'd0; wd = 16'h4321; ra1 = 4'd0; ra2 = 4'd0;
        @(negedge clk);
        regwrite = 1'b0;
        chk("dropped_w0_rd1_z", rd1_z, 16'h0000);
        chk("w0_rd1_n", rd1_n, BYPASS ? 16'h4321 : 16'h1234);

        for (int i = 0; i < 4; i++) wr(t_addr[i], t_data[i]);
        for (int i = 0; i < 4; i++) begin
            rd(t_addr[i], 4'd3);
            chk("table_rd1", rd1_z, t_data[i]);
            chk("table_rd2", rd2_z, 16'hBEEF);
        end

        wr(4'd7, 16'hAAAA);
        rd(4'd7, 4'd7);
        chk("aaaa_rd1", rd1_z, 16'hAAAA);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clear_busy", busy_z, 1'b1);
        count_busy(1'b1, n);
        chk("clear_sweep_edges", n, 16);
        rd(4'd7, 4'd8);
        chk("cleared_e7", rd1_z, 16'h0000);
        chk("cleared_e8", rd2_z, 16'h0000);

        wr(4'd9, 16'h9999);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_sweep_reset_busy", busy_z, 1'b1);
        reset = 1'b0;
        count_busy(1'b0, n);
        chk("restart_sweep_edges", n, 16);
        rd(4'd9, 4'd3);
        chk("restart_e9", rd1_z, 16'h0000);
        chk("restart_e3", rd2_n, 16'h0000);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
